// File: rtl/sa_autosa_sdp_rdma_eg_split.sv
// Egress splitter: unpacks masked multi-slot words into OUT_W sub-beats and
// frames them into a layer of reg_beat_total beats.
module sa_autosa_sdp_rdma_eg_split #(
  parameter int SLOT_W = 256,
  parameter int NSLOT  = 4,
  parameter int OUT_W  = 128
) (
  input  logic                          autosa_core_clk,
  input  logic                          autosa_core_rst,
  input  logic                          reg_op_en,
  input  logic [15:0]                   reg_beat_total,
  input  logic                          inp_pvld,
  output logic                          inp_prdy,
  input  logic [NSLOT*SLOT_W+NSLOT-1:0] inp_data,
  output logic                          out_pvld,
  input  logic                          out_prdy,
  output logic [OUT_W-1:0]              out_data,
  output logic                          out_last,
  output logic                          op_done,
  output logic                          busy
);

  localparam int NSUB   = SLOT_W / OUT_W;
  localparam int SUB_W  = (NSUB > 1) ? $clog2(NSUB) : 1;
  localparam int SIDX_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int DATA_W = NSLOT * SLOT_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         total_q, total_d;
  logic [NSLOT-1:0]    mask_q, mask_d;
  logic [SUB_W-1:0]    sub_q, sub_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                run_s, out_pvld_s, out_fire_s, last_beat_s;
  logic                word_end_s, inp_prdy_s, inp_fire_s;
  logic [SIDX_W-1:0]   slot_s;
  logic [NSLOT-1:0]    rest_mask_s;
  logic [SLOT_W-1:0]   slot_word_s;

  function automatic logic [SIDX_W-1:0] low_slot(input logic [NSLOT-1:0] m);
    low_slot = {SIDX_W{1'b0}};
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (m[i]) low_slot = SIDX_W'(i);
    end
  endfunction

  always_ff @(posedge autosa_core_clk or posedge autosa_core_rst) begin
    if (autosa_core_rst) state_q <= ST_IDLE;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (reg_op_en) state_d = (reg_beat_total == 16'd0) ? ST_DONE : ST_RUN;
        else           state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (out_fire_s && last_beat_s) state_d = ST_DONE;
        else                           state_d = ST_RUN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The held word is live while any mask bit remains; the lowest set bit is the slot on the wire.
  always_comb begin
    run_s       = (state_q == ST_RUN);
    busy        = (state_q != ST_IDLE);
    op_done     = (state_q == ST_DONE);
    slot_s      = low_slot(mask_q);
    rest_mask_s = mask_q & (mask_q - NSLOT'(1));
    slot_word_s = data_q[int'(slot_s)*SLOT_W +: SLOT_W];
    out_data    = slot_word_s[int'(sub_q)*OUT_W +: OUT_W];
    out_pvld_s  = run_s && (mask_q != {NSLOT{1'b0}});
    last_beat_s = (cnt_q == total_q - 16'd1);
    out_fire_s  = out_pvld_s && out_prdy;
    word_end_s  = (sub_q == SUB_W'(NSUB - 1)) && (rest_mask_s == {NSLOT{1'b0}});
    inp_prdy_s  = run_s && ((mask_q == {NSLOT{1'b0}}) ||
                            (out_fire_s && word_end_s && !last_beat_s));
    inp_fire_s  = inp_pvld && inp_prdy_s;
    out_pvld    = out_pvld_s;
    out_last    = out_pvld_s && last_beat_s;
    inp_prdy    = inp_prdy_s;
  end

  always_comb begin
    cnt_d   = cnt_q;
    total_d = total_q;
    mask_d  = mask_q;
    sub_d   = sub_q;
    data_d  = data_q;
    if (state_q == ST_IDLE) begin
      mask_d = {NSLOT{1'b0}};
      sub_d  = {SUB_W{1'b0}};
      if (reg_op_en) begin
        cnt_d   = 16'd0;
        total_d = reg_beat_total;
      end else begin
        cnt_d   = cnt_q;
        total_d = total_q;
      end
    end else if (state_q != ST_RUN) begin
      mask_d = {NSLOT{1'b0}};
      sub_d  = {SUB_W{1'b0}};
    end else if (out_fire_s && last_beat_s) begin
      // Layer ends here: leftover sub-beats of the held word are dropped.
      cnt_d  = cnt_q + 16'd1;
      mask_d = {NSLOT{1'b0}};
      sub_d  = {SUB_W{1'b0}};
    end else begin
      if (out_fire_s) begin
        cnt_d = cnt_q + 16'd1;
        if (sub_q == SUB_W'(NSUB - 1)) begin
          mask_d = rest_mask_s;
          sub_d  = {SUB_W{1'b0}};
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end else begin
        cnt_d = cnt_q;
      end
      if (inp_fire_s) begin
        data_d = inp_data[DATA_W-1:0];
        mask_d = inp_data[DATA_W +: NSLOT];
        sub_d  = {SUB_W{1'b0}};
      end else begin
        data_d = data_q;
      end
    end
  end

  always_ff @(posedge autosa_core_clk or posedge autosa_core_rst) begin
    if (autosa_core_rst) begin
      cnt_q   <= 16'd0;
      total_q <= 16'd0;
      mask_q  <= {NSLOT{1'b0}};
      sub_q   <= {SUB_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
    end else begin
      cnt_q   <= cnt_d;
      total_q <= total_d;
      mask_q  <= mask_d;
      sub_q   <= sub_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_sa_autosa_sdp_rdma_eg_split.sv
// Scoreboard bench for sa_autosa_sdp_rdma_eg_split: expected sub-beats are queued
// when a word is accepted and compared as the DUT hands them off.
module tb_sa_autosa_sdp_rdma_eg_split;

  localparam int SLOT_W = 256;
  localparam int NSLOT  = 4;
  localparam int OUT_W  = 128;
  localparam int NSUB   = SLOT_W / OUT_W;
  localparam int IN_W   = NSLOT * SLOT_W + NSLOT;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              reg_op_en = 1'b0;
  logic [15:0]       reg_beat_total = 16'd0;
  logic              inp_pvld = 1'b0;
  logic              inp_prdy;
  logic [IN_W-1:0]   inp_data = '0;
  logic              out_pvld;
  logic              out_prdy = 1'b1;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;
  logic              op_done;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [OUT_W:0] exp_q[$];
  int beat_cyc[$];
  int beat_cnt, done_cnt, done_cyc, last_cyc, layer_total, emitted, start_cyc;
  logic done_busy;
  bit prdy_rand = 1'b0;
  logic prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data;
  logic [OUT_W:0] mon_e;

  sa_autosa_sdp_rdma_eg_split #(.SLOT_W(SLOT_W), .NSLOT(NSLOT), .OUT_W(OUT_W)) dut (
    .autosa_core_clk(clk),
    .autosa_core_rst(rst),
    .reg_op_en(reg_op_en),
    .reg_beat_total(reg_beat_total),
    .inp_pvld(inp_pvld),
    .inp_prdy(inp_prdy),
    .inp_data(inp_data),
    .out_pvld(out_pvld),
    .out_prdy(out_prdy),
    .out_data(out_data),
    .out_last(out_last),
    .op_done(op_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    out_prdy = prdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Output monitor: stall stability, scoreboard pop on handshake, op_done capture.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (out_pvld !== 1'b1 || out_data !== prev_data)
          $display("FAIL stall_stable: got pvld=%b data=%h want pvld=1 data=%h",
                   out_pvld, out_data, prev_data);
        else n_pass++;
      end
      if (out_pvld === 1'b1 && out_prdy === 1'b1) begin
        beat_cnt++;
        beat_cyc.push_back(cyc);
        if (out_last === 1'b1) last_cyc = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL beat_unexpected: got last=%b data=%h want no beat", out_last, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          if ({out_last, out_data} !== mon_e)
            $display("FAIL beat_%0d: got last=%b data=%h want last=%b data=%h",
                     beat_cnt, out_last, out_data, mon_e[OUT_W], mon_e[OUT_W-1:0]);
          else n_pass++;
        end
      end
      if (op_done === 1'b1) begin
        done_cnt++;
        done_cyc  = cyc;
        done_busy = busy;
      end
      prev_stall = (out_pvld === 1'b1) && (out_prdy !== 1'b1);
      prev_data  = out_data;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish before 300us");
    $fatal(1);
  end

  function automatic logic [IN_W-1:0] make_word(input logic [NSLOT-1:0] m);
    logic [IN_W-1:0] w;
    w = '0;
    for (int i = 0; i < NSLOT * SLOT_W / 32; i++) w[i*32 +: 32] = $urandom;
    w[IN_W-1 -: NSLOT] = m;
    return w;
  endfunction

  task automatic push_expect(input logic [IN_W-1:0] w);
    for (int s = 0; s < NSLOT; s++)
      for (int h = 0; h < NSUB; h++)
        if (w[NSLOT*SLOT_W + s] && emitted < layer_total) begin
          exp_q.push_back({(emitted == layer_total - 1), w[(s*NSUB + h)*OUT_W +: OUT_W]});
          emitted++;
        end
  endtask

  task automatic start_layer(input int total);
    layer_total = total; emitted = 0; beat_cnt = 0; done_cnt = 0;
    last_cyc = -1; done_cyc = -1; done_busy = 1'b0;
    beat_cyc.delete();
    reg_op_en = 1'b1; reg_beat_total = 16'(total); start_cyc = cyc;
    @(posedge clk); #1;
    reg_op_en = 1'b0;
  endtask

  task automatic send_word(input logic [IN_W-1:0] w, input int budget, output int acc);
    acc = -1; inp_data = w; inp_pvld = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (inp_prdy === 1'b1) begin
        acc = cyc;
        push_expect(w);
        break;
      end
      @(posedge clk); #1;
    end
    if (acc >= 0) begin
      @(posedge clk); #1;
    end
    inp_pvld = 1'b0;
    n_checks++;
    if (acc < 0) $display("FAIL accept_timeout: got no inp_prdy want accept within %0d cycles", budget);
    else n_pass++;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) break;
    end
    n_checks++;
    if (done_cnt == 0) $display("FAIL done_timeout: got op_done=0 want op_done within %0d cycles", budget);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; reg_op_en = 1'b1; reg_beat_total = 16'd5; inp_pvld = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (inp_prdy !== 1'b0) $display("FAIL rst_inp_prdy: got %b want 0", inp_prdy); else n_pass++;
    n_checks++; if (out_pvld !== 1'b0) $display("FAIL rst_out_pvld: got %b want 0", out_pvld); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL rst_out_last: got %b want 0", out_last); else n_pass++;
    n_checks++; if (op_done !== 1'b0) $display("FAIL rst_op_done: got %b want 0", op_done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    reg_op_en = 1'b0; inp_pvld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_word();
    int a, first;
    start_layer(8);
    send_word(make_word(4'hf), 20, a);
    wait_done(50);
    first = (beat_cyc.size() > 0) ? beat_cyc[0] : -100;
    n_checks++; if (beat_cnt !== 8) $display("FAIL full_beats: got %0d want 8", beat_cnt); else n_pass++;
    n_checks++; if (first !== a + 1) $display("FAIL full_first_lat: got cycle %0d want %0d", first, a + 1); else n_pass++;
    n_checks++; if (last_cyc !== first + 7) $display("FAIL full_last_cycle: got %0d want %0d", last_cyc, first + 7); else n_pass++;
    n_checks++; if (done_cyc !== last_cyc + 1) $display("FAIL full_done_cycle: got %0d want %0d", done_cyc, last_cyc + 1); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL full_leftover: got %0d want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int a1, a2, b4, first, lastb;
    start_layer(6);
    send_word(make_word(4'h3), 20, a1);
    send_word(make_word(4'h1), 20, a2);
    wait_done(50);
    b4    = (beat_cyc.size() > 3) ? beat_cyc[3] : -100;
    first = (beat_cyc.size() > 0) ? beat_cyc[0] : -100;
    lastb = (beat_cyc.size() > 5) ? beat_cyc[5] : -200;
    n_checks++; if (beat_cnt !== 6) $display("FAIL b2b_beats: got %0d want 6", beat_cnt); else n_pass++;
    n_checks++; if (a2 !== b4) $display("FAIL b2b_prdy_cycle: got %0d want %0d", a2, b4); else n_pass++;
    n_checks++; if (lastb - first !== 5) $display("FAIL b2b_bubble: got span %0d want 5", lastb - first); else n_pass++;
    n_checks++; if (done_cyc !== last_cyc + 1) $display("FAIL b2b_done_cycle: got %0d want %0d", done_cyc, last_cyc + 1); else n_pass++;
  endtask

  task automatic test_sparse_mask();
    int a;
    start_layer(4);
    send_word(make_word(4'b1010), 20, a);
    wait_done(50);
    n_checks++; if (beat_cnt !== 4) $display("FAIL sparse_beats: got %0d want 4", beat_cnt); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL sparse_leftover: got %0d want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_early_last();
    int a, bad, post, b3;
    start_layer(3);
    send_word(make_word(4'hf), 20, a);
    inp_data = make_word(4'hf); inp_pvld = 1'b1;
    bad = 0; post = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (inp_prdy === 1'b1) bad++;
      if (done_cnt > 0) post++;
      if (post >= 2) break;
    end
    inp_pvld = 1'b0;
    b3 = (beat_cyc.size() > 2) ? beat_cyc[2] : -100;
    n_checks++; if (beat_cnt !== 3) $display("FAIL early_beats: got %0d want 3", beat_cnt); else n_pass++;
    n_checks++; if (last_cyc !== b3) $display("FAIL early_last_beat: got cycle %0d want %0d", last_cyc, b3); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL early_accept: got %0d accepts want 0", bad); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL early_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    n_checks++; if (done_busy !== 1'b1) $display("FAIL early_busy_in_done: got %b want 1", done_busy); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL early_busy_after: got %b want 0", busy); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_stall_mask0();
    logic [NSLOT-1:0] masks[7] = '{4'h5, 4'h0, 4'hc, 4'h0, 4'h0, 4'h9, 4'hf};
    int a;
    prdy_rand = 1'b1;
    start_layer(20);
    foreach (masks[i]) send_word(make_word(masks[i]), 200, a);
    wait_done(400);
    prdy_rand = 1'b0;
    n_checks++; if (beat_cnt !== 20) $display("FAIL stall_beats: got %0d want 20", beat_cnt); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL stall_leftover: got %0d want 0", exp_q.size()); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int a;
    start_layer(10);
    send_word(make_word(4'hf), 20, a);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (inp_prdy !== 1'b0) $display("FAIL mid_rst_inp_prdy: got %b want 0", inp_prdy); else n_pass++;
    n_checks++; if (out_pvld !== 1'b0) $display("FAIL mid_rst_out_pvld: got %b want 0", out_pvld); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL mid_rst_out_last: got %b want 0", out_last); else n_pass++;
    n_checks++; if (op_done !== 1'b0) $display("FAIL mid_rst_op_done: got %b want 0", op_done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    done_cnt = 0; beat_cnt = 0;
    repeat (5) begin @(posedge clk); #1; end
    n_checks++; if (done_cnt !== 0) $display("FAIL mid_no_done: got %0d want 0", done_cnt); else n_pass++;
    n_checks++; if (beat_cnt !== 0) $display("FAIL mid_no_resume: got %0d beats want 0", beat_cnt); else n_pass++;
    start_layer(0);
    wait_done(10);
    n_checks++; if (done_cyc !== start_cyc + 1) $display("FAIL zero_done_cycle: got %0d want %0d", done_cyc, start_cyc + 1); else n_pass++;
    n_checks++; if (beat_cnt !== 0) $display("FAIL zero_beats: got %0d want 0", beat_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_back_to_back();
    test_sparse_mask();
    test_early_last();
    test_stall_mask0();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
